// File: rtl/noc_flit_pkg.sv
// Shared field layout for the router flit channel and the credit-return channel,
// plus helpers that assemble flits and head-flit headers.
package noc_flit_pkg;

   localparam int unsigned NUM_VCS     = 4;
   localparam int unsigned VC_IDX_W    = 2;
   localparam int unsigned FLIT_DATA_W = 32;
   localparam int unsigned ADDR_W      = 4;
   localparam int unsigned LEN_W       = 4;
   localparam int unsigned CHAN_W      = 38;
   localparam int unsigned FC_W        = 3;

   localparam int unsigned CH_VALID    = 0;
   localparam int unsigned CH_VC_LSB   = 1;
   localparam int unsigned CH_HEAD     = 3;
   localparam int unsigned CH_TAIL     = 4;
   localparam int unsigned CH_DATA_LSB = 6;

   localparam int unsigned FC_VALID  = 0;
   localparam int unsigned FC_VC_LSB = 1;

   localparam int unsigned HDR_DEST_LSB = 0;
   localparam int unsigned HDR_SRC_LSB  = 4;
   localparam int unsigned HDR_LEN_LSB  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StVcSel,
      StBody
   } state_e;

   function automatic logic [CHAN_W-1:0] make_flit(input logic [VC_IDX_W-1:0]    vc,
                                                  input logic                    head,
                                                  input logic                    tail,
                                                  input logic [FLIT_DATA_W-1:0] payload);
      logic [CHAN_W-1:0] f;
      f                                = '0;
      f[CH_VALID]                      = 1'b1;
      f[CH_VC_LSB +: VC_IDX_W]         = vc;
      f[CH_HEAD]                       = head;
      f[CH_TAIL]                       = tail;
      f[CH_DATA_LSB +: FLIT_DATA_W]    = payload;
      return f;
   endfunction

   function automatic logic [FLIT_DATA_W-1:0] make_header(input logic [ADDR_W-1:0] dest,
                                                         input logic [ADDR_W-1:0] src,
                                                         input logic [LEN_W-1:0]  len_m1);
      logic [FLIT_DATA_W-1:0] h;
      h                            = '0;
      h[HDR_DEST_LSB +: ADDR_W]    = dest;
      h[HDR_SRC_LSB +: ADDR_W]     = src;
      h[HDR_LEN_LSB +: LEN_W]      = len_m1;
      return h;
   endfunction

endpackage

// File: rtl/noc_credit_tracker.sv
// Per-VC credit counters: decrement on each launched flit, increment on each
// credit return, saturate at BUF_DEPTH and raise a sticky overflow flag.
module noc_credit_tracker
   import noc_flit_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                send,
   input  logic [VC_IDX_W-1:0] send_vc,
   input  logic                ret_valid,
   input  logic [VC_IDX_W-1:0] ret_vc,
   output logic [NUM_VCS-1:0]  nonzero,
   output logic                overflow
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   logic [CNT_W-1:0] cnt_q [NUM_VCS];
   logic [CNT_W-1:0] cnt_d [NUM_VCS];
   logic [CNT_W:0]   sum   [NUM_VCS];
   logic             overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q;
      for (int v = 0; v < NUM_VCS; v++) begin
         // One extra bit so a return onto a full counter is visible before saturation.
         sum[v] = {1'b0, cnt_q[v]}
                + (CNT_W+1)'(ret_valid && (ret_vc == VC_IDX_W'(v)))
                - (CNT_W+1)'(send && (send_vc == VC_IDX_W'(v)));
         if (sum[v] > (CNT_W+1)'(BUF_DEPTH)) begin
            cnt_d[v]   = CNT_W'(BUF_DEPTH);
            overflow_d = 1'b1;
         end else begin
            cnt_d[v] = sum[v][CNT_W-1:0];
         end
         nonzero[v] = (cnt_q[v] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            cnt_q[v] <= CNT_W'(BUF_DEPTH);
         end
         overflow_q <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            cnt_q[v] <= cnt_d[v];
         end
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: rtl/noc_flit_injector.sv
// Host-side injector for one router terminal port: turns a descriptor plus a payload
// word stream into head/body/tail flits on a credit-managed virtual channel.
module noc_flit_injector
   import noc_flit_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      router_address,
   input  logic                   pkt_valid,
   output logic                   pkt_ready,
   input  logic [ADDR_W-1:0]      pkt_dest,
   input  logic [LEN_W-1:0]       pkt_len_m1,
   input  logic                   data_valid,
   output logic                   data_ready,
   input  logic [FLIT_DATA_W-1:0] data,
   output logic [CHAN_W-1:0]      channel_out,
   input  logic [FC_W-1:0]        flow_ctrl_in,
   output logic                   error
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    word_q, word_d;
   logic [VC_IDX_W-1:0] vc_q, vc_d;
   logic [VC_IDX_W-1:0] rr_q, rr_d;
   logic [CHAN_W-1:0]   chan_q, chan_d;
   logic                pkt_ready_q, pkt_ready_d;

   logic [NUM_VCS-1:0]  credit_ok;
   logic                send;
   logic [VC_IDX_W-1:0] send_vc;
   logic                sel_found;
   logic [VC_IDX_W-1:0] sel_vc;
   logic [VC_IDX_W-1:0] cand;

   noc_credit_tracker #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_credit_tracker (
      .clk       (clk),
      .reset     (reset),
      .send      (send),
      .send_vc   (send_vc),
      .ret_valid (flow_ctrl_in[FC_VALID]),
      .ret_vc    (flow_ctrl_in[FC_VC_LSB +: VC_IDX_W]),
      .nonzero   (credit_ok),
      .overflow  (error)
   );

   // Scan from the farthest offset down so the VC nearest the RR pointer wins.
   always_comb begin
      sel_found = 1'b0;
      sel_vc    = rr_q;
      cand      = rr_q;
      for (int i = NUM_VCS - 1; i >= 0; i--) begin
         cand = rr_q + VC_IDX_W'(i);
         if (credit_ok[cand]) begin
            sel_found = 1'b1;
            sel_vc    = cand;
         end
      end
   end

   assign data_ready = (state_q == StBody) && credit_ok[vc_q];

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      len_d   = len_q;
      word_d  = word_q;
      vc_d    = vc_q;
      rr_d    = rr_q;
      chan_d  = '0;
      send    = 1'b0;
      send_vc = vc_q;
      unique case (state_q)
         StIdle: begin
            if (pkt_valid && pkt_ready_q) begin
               dest_d  = pkt_dest;
               len_d   = pkt_len_m1;
               word_d  = '0;
               state_d = StVcSel;
            end
         end
         StVcSel: begin
            if (sel_found) begin
               vc_d    = sel_vc;
               send    = 1'b1;
               send_vc = sel_vc;
               chan_d  = make_flit(sel_vc, 1'b1, 1'b0,
                                   make_header(dest_q, router_address, len_q));
               rr_d    = sel_vc + 1'b1;
               state_d = StBody;
            end
         end
         StBody: begin
            if (data_valid && data_ready) begin
               send   = 1'b1;
               chan_d = make_flit(vc_q, 1'b0, word_q == len_q, data);
               word_d = word_q + 1'b1;
               if (word_q == len_q) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Registered from the next state so ready stays low in the first cycle after reset.
      pkt_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         dest_q      <= '0;
         len_q       <= '0;
         word_q      <= '0;
         vc_q        <= '0;
         rr_q        <= '0;
         chan_q      <= '0;
         pkt_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         len_q       <= len_d;
         word_q      <= word_d;
         vc_q        <= vc_d;
         rr_q        <= rr_d;
         chan_q      <= chan_d;
         pkt_ready_q <= pkt_ready_d;
      end
   end

   assign channel_out = chan_q;
   assign pkt_ready   = pkt_ready_q;

endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Host-side transmitter for one router injection port of the mesh.
- Accepts a packet descriptor and a payload word stream from the host, and emits head/body/tail flits on a 38-bit router input channel.
- Honours credit-based flow control returned on the 3-bit flow-control channel, with per-VC credit counters.
- One instance is placed per router terminal port, driving `channel_router_N_ip_K` and consuming `flow_ctrl_router_N_ip_K`.

Parameters:
- NUM_VCS, 4, virtual channels per port; fixed by the 2-bit VC field.
- BUF_DEPTH, 8, flit buffer depth per VC at the router input, which is also the initial credits per VC.
- FLIT_DATA_W, 32, flit payload width.
- ADDR_W, 4, router address width; [0:1] is column, [2:3] is row.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- router_address  in  4  this terminal's own address, inserted as the source in head flits
- pkt_valid  in  1  packet descriptor valid
- pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready
- pkt_dest  in  4  destination router address
- pkt_len_m1  in  4  payload word count minus 1 (1..16 words)
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted when data_valid && data_ready
- data  in  32  payload word
- channel_out  out  38  flit channel to the router input: [0] valid, [1:2] vc, [3] head, [4] tail, [5] reserved = 0, [6:37] data
- flow_ctrl_in  in  3  credit return from the router: [0] valid, [1:2] vc
- error  out  1  sticky credit-overflow flag

Behaviour:
- Reset values:
  - channel_out = 0; pkt_ready = 0; data_ready = 0; error = 0.
  - All credit counters = BUF_DEPTH; RR pointer = VC 0.
  - FSM returns to IDLE. Reset mid-packet abandons the packet; no tail flit is sent.
- channel_out is fully registered. Valid is 0 in every cycle where no flit is launched, and in that case all other fields are 0.
- FSM states:
  - IDLE:
    - pkt_ready = 1.
    - On handshake: latch dest, len_m1; clear the word counter; go to VCSEL.
  - VCSEL:
    - Round-robin search over the VCs, starting at the RR pointer, for credit[vc] > 0.
    - If none has credit, stay in VCSEL.
    - On a hit: latch vc; launch the head flit with valid=1, head=1, tail=0, vc.
    - Head data: [0:3] dest, [4:7] router_address, [8:11] len_m1, [12:31] = 0.
    - Set RR pointer = vc+1 mod 4; go to BODY.
  - BODY:
    - data_ready = (credit[vc] > 0), using the registered counter value.
    - On handshake: launch a body flit on the same vc with data = word.
    - tail = 1 iff word counter == len_m1; the counter increments per word.
    - After the tail flit: go to IDLE.
- Latency:
  - Descriptor accepted in cycle T → head flit on channel_out at T+2 if a credit is free.
  - Payload word accepted in cycle U → flit on channel_out at U+1.
- A head flit is never also a tail flit; the minimum packet length is 2 flits.
- The VC is fixed for the whole packet. Only one packet is in flight at a time.
- Credit arithmetic, per VC, each cycle: next = cnt − sent + returned.
  - Simultaneous send and return on the same VC leaves the count unchanged.
  - A return that would push the count above BUF_DEPTH: the count holds at BUF_DEPTH and error sets to 1, sticky until reset.
  - A return whose vc field is outside 0..NUM_VCS−1 cannot occur (2-bit field).
- Credits returned in cycle C are usable for a send decision in C+1.
- pkt_ready and data_ready never both assert in the same cycle.

Decomposition:
- Shared package `noc_flit_pkg`:
  - Channel field index constants (valid, vc, head, tail, data ranges) and the flow-control field indices.
  - NUM_VCS, VC_IDX_W = 2, FLIT_DATA_W, channel width 38, flow-control width 3.
  - Head-flit header field offsets (dest, src, len).
- One natural sub-module, `noc_credit_tracker`:
  - NUM_VCS counters of width clog2(BUF_DEPTH+1).
  - Inputs: send pulse and vc, credit return.
  - Outputs: per-VC nonzero flags and the overflow flag.
- The FSM, round-robin select and flit formatting stay in the top.

Test Plan:
1. Reset, then pkt dest=4'b1010, len_m1=2, words A0,A1,A2 streamed back-to-back:
   - head flit at T+2 on vc0 with data[0:3]=1010 and data[8:11]=2;
   - three body flits on consecutive cycles on vc0, the last with tail=1;
   - credit[0] = 4.
2. No credit returns; send two 4-word packets:
   - the first uses vc0 (5 flits, credit[0]=3), the second uses vc1;
   - after draining all VCs to 0, data_ready stays 0 and channel valid stays 0 until a return (1, vc) arrives, then the next flit appears one cycle after the following accepted word.
3. Simultaneous send on vc2 and credit return on vc2 in the same cycle → credit[2] unchanged; no error.
4. Credit return on vc3 while credit[3] = 8 → error rises next cycle and stays 1; credit[3] stays 8.
5. Assert reset in the middle of BODY after 2 of 5 words:
   - next cycle channel_out = 0, pkt_ready = 0, data_ready = 0;
   - all credits = 8;
   - a fresh packet then starts on vc0.
6. data_valid held low for 5 cycles in BODY → no flits are emitted and channel valid = 0; the packet resumes on the same vc with the correct tail placement.
